// File: rtl/gshare_predictor.sv
// gshare_predictor: PHT of saturating counters with optional global-history
// indexing, post-reset init sweep and RISC-V JAL/JALR/BRANCH decode.
// Define PREDICTOR_GSHARE_EN to XOR speculative history into the PHT index;
// left undefined the predictor is a plain bimodal table.
module gshare_predictor #(
    parameter int unsigned PHT_BITS  = 8,
    parameter int unsigned HIST_BITS = 8,
    parameter int unsigned CTR_BITS  = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                enable_from_fetcher,
    input  logic [31:0]         pc_from_fetcher,
    input  logic [31:0]         inst_from_fetcher,
    output logic [31:0]         imm_to_fetcher,
    output logic                jump_predict_flag_to_fetcher,
    output logic                is_jalr_inst_to_fetcher,
    output logic [PHT_BITS-1:0] pht_index_to_fetcher,
    output logic                ready_to_fetcher,
    input  logic                enable_from_reorderbuffer,
    input  logic [PHT_BITS-1:0] pht_index_from_reorderbuffer,
    input  logic                jump_result_from_reorderbuffer,
    input  logic                clear_from_reorderbuffer
);

    localparam int unsigned PHT_SIZE = 1 << PHT_BITS;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state;
    logic [PHT_BITS-1:0] init_ptr;
    logic [CTR_BITS-1:0] pht [PHT_SIZE];

    logic [6:0]          opcode;
    logic                is_jal;
    logic                is_branch;
    logic [PHT_BITS-1:0] pc_idx;
    logic [CTR_BITS-1:0] lookup_ctr;
    logic [CTR_BITS-1:0] commit_ctr;
    logic [CTR_BITS-1:0] commit_ctr_next;

    // Bits of pc outside the index field never influence the prediction.
    wire unused_pc = ^{pc_from_fetcher[31:PHT_BITS+2], pc_from_fetcher[1:0]};

    assign opcode    = inst_from_fetcher[6:0];
    assign is_jal    = (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BRANCH);
    assign pc_idx    = pc_from_fetcher[PHT_BITS+1:2];

`ifdef PREDICTOR_GSHARE_EN
    logic [HIST_BITS-1:0] spec_ghr;
    logic [HIST_BITS-1:0] commit_ghr;
    logic [HIST_BITS-1:0] commit_ghr_next;

    assign pht_index_to_fetcher = pc_idx ^ PHT_BITS'(spec_ghr);
    assign commit_ghr_next = enable_from_reorderbuffer
                           ? HIST_BITS'({commit_ghr, jump_result_from_reorderbuffer})
                           : commit_ghr;
`else
    // Bimodal build: history controls are accepted but ignored.
    wire unused_bimodal = ^{clear_from_reorderbuffer, enable_from_fetcher, HIST_BITS'(0)};

    assign pht_index_to_fetcher = pc_idx;
`endif

    // Fetch-side decode and lookup, zero latency.
    assign imm_to_fetcher = is_jal
        ? {{12{inst_from_fetcher[31]}}, inst_from_fetcher[19:12], inst_from_fetcher[20],
           inst_from_fetcher[30:21], 1'b0}
        : {{20{inst_from_fetcher[31]}}, inst_from_fetcher[7], inst_from_fetcher[30:25],
           inst_from_fetcher[11:8], 1'b0};
    assign is_jalr_inst_to_fetcher      = (opcode == OP_JALR);
    assign lookup_ctr                   = pht[pht_index_to_fetcher];
    assign jump_predict_flag_to_fetcher = is_jal
                                        | (is_branch && (state == S_RUN) && lookup_ctr[CTR_BITS-1]);
    assign ready_to_fetcher             = (state == S_RUN);

    // Saturating counter update for the committing branch.
    assign commit_ctr = pht[pht_index_from_reorderbuffer];
    always_comb begin
        commit_ctr_next = commit_ctr;
        if (jump_result_from_reorderbuffer) begin
            if (commit_ctr != CTR_MAX) commit_ctr_next = commit_ctr + CTR_BITS'(1);
        end else begin
            if (commit_ctr != '0) commit_ctr_next = commit_ctr - CTR_BITS'(1);
        end
    end

    // PHT storage: init sweep writes WNT, run mode applies commits.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (state == S_INIT) begin
                pht[init_ptr] <= CTR_WNT;
            end else if (enable_from_reorderbuffer) begin
                pht[pht_index_from_reorderbuffer] <= commit_ctr_next;
            end
        end
    end

    // Init/run FSM with sweep pointer and global histories.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= S_INIT;
            init_ptr   <= '0;
`ifdef PREDICTOR_GSHARE_EN
            spec_ghr   <= '0;
            commit_ghr <= '0;
`endif
        end else if (rdy_in) begin
            if (state == S_INIT) begin
                init_ptr <= init_ptr + PHT_BITS'(1);
                if (&init_ptr) state <= S_RUN;
            end else begin
`ifdef PREDICTOR_GSHARE_EN
                commit_ghr <= commit_ghr_next;
                if (clear_from_reorderbuffer) begin
                    spec_ghr <= commit_ghr_next;
                end else if (enable_from_fetcher && is_branch) begin
                    spec_ghr <= HIST_BITS'({spec_ghr, jump_predict_flag_to_fetcher});
                end
`endif
            end
        end
    end

endmodule
